// File: rtl/tge_read_depacketizer.sv
// tge_read_depacketizer: takes 10GbE rx frames of one header word plus
// PKT_LEN payload words, keeps only complete, clean frames in a ring of
// N_BUFS packet slots in dual-port RAM, and streams committed packets out
// in order under ready/valid flow control.
module tge_read_depacketizer #(
  parameter int DATA_WIDTH = 64,
  parameter int PKT_LEN    = 128,
  parameter int N_BUFS     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_eof,
  input  logic                  rx_bad_frame,
  input  logic                  rx_overrun,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_sof,
  output logic                  dout_eof,
  output logic [DATA_WIDTH-1:0] pkt_seq,
  output logic [31:0]           drop_count,
  output logic [31:0]           seq_gap_count
);

  localparam int SW = (N_BUFS > 1) ? $clog2(N_BUFS) : 1;
  localparam int WW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int AW = (N_BUFS * PKT_LEN > 1) ? $clog2(N_BUFS * PKT_LEN) : 1;
  localparam logic [WW-1:0] LAST = WW'(PKT_LEN - 1);

  typedef enum logic [1:0] {HDR, PAYLOAD, DISCARD} wstate_t;

  wstate_t state, state_nxt;

  // write side
  logic [WW-1:0]                    wcnt;
  logic [SW-1:0]                    wslot;
  logic [DATA_WIDTH-1:0]            hdr_q;
  logic                             ovr;
  logic [DATA_WIDTH-1:0]            last_seq;
  logic                             have_seq;
  logic                             hdr_take, wr_en, wcnt_inc, commit, drop;
  logic [AW-1:0]                    wr_addr;

  // slot bookkeeping
  logic [N_BUFS-1:0]                full;
  logic [N_BUFS-1:0][DATA_WIDTH-1:0] slot_hdr;

  // read side
  logic [DATA_WIDTH-1:0]            mem [N_BUFS*PKT_LEN];
  logic [DATA_WIDTH-1:0]            rd_data;
  logic [WW-1:0]                    rcnt;
  logic [SW-1:0]                    rslot, oslot;
  logic                             adv, rd_en, rd_free;
  logic [AW-1:0]                    rd_addr;

  function automatic logic [SW-1:0] slot_inc(input logic [SW-1:0] s);
    return (N_BUFS == 1) ? '0 : s + SW'(1);
  endfunction

  assign wr_addr = AW'(32'(wslot) * 32'(PKT_LEN) + 32'(wcnt));
  assign rd_addr = AW'(32'(rslot) * 32'(PKT_LEN) + 32'(rcnt));

  // write FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HDR;
    else        state <= state_nxt;
  end

  // write FSM next state and per-word control strobes
  always_comb begin
    state_nxt = state;
    hdr_take  = 1'b0;
    wr_en     = 1'b0;
    wcnt_inc  = 1'b0;
    commit    = 1'b0;
    drop      = 1'b0;
    case (state)
      HDR: if (rx_valid) begin
        // A one-word frame ends here whether or not a slot is free, so it
        // never parks in DISCARD and swallows the next frame.
        if (rx_eof) drop = 1'b1;
        else if (full[wslot]) begin
          drop      = 1'b1;
          state_nxt = DISCARD;
        end else begin
          hdr_take  = 1'b1;
          state_nxt = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (rx_overrun) begin
          drop      = 1'b1;
          state_nxt = (rx_valid && rx_eof) ? HDR : DISCARD;
        end else if (rx_valid) begin
          wr_en = 1'b1;
          if (rx_eof) begin
            state_nxt = HDR;
            if (wcnt == LAST && !rx_bad_frame && !ovr) commit = 1'b1;
            else                                       drop   = 1'b1;
          end else if (wcnt == LAST) begin
            drop      = 1'b1;
            state_nxt = DISCARD;
          end else begin
            wcnt_inc = 1'b1;
          end
        end
      end
      DISCARD: if (rx_valid && rx_eof) state_nxt = HDR;
      default: state_nxt = HDR;
    endcase
  end

  // header latch, word counter, write pointer, sequence and drop counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt          <= '0;
      hdr_q         <= '0;
      ovr           <= 1'b0;
      wslot         <= '0;
      slot_hdr      <= '0;
      last_seq      <= '0;
      have_seq      <= 1'b0;
      drop_count    <= '0;
      seq_gap_count <= '0;
    end else begin
      if (hdr_take) begin
        hdr_q <= rx_data;
        wcnt  <= '0;
        ovr   <= rx_overrun;
      end else if (wcnt_inc) begin
        wcnt <= wcnt + WW'(1);
      end
      if (commit) begin
        slot_hdr[wslot] <= hdr_q;
        wslot           <= slot_inc(wslot);
        last_seq        <= hdr_q;
        have_seq        <= 1'b1;
        if (have_seq && hdr_q != last_seq + DATA_WIDTH'(1) && seq_gap_count != '1)
          seq_gap_count <= seq_gap_count + 32'd1;
      end
      if (drop && drop_count != '1) drop_count <= drop_count + 32'd1;
    end
  end

  // slot full flags: set on commit, cleared when the slot's eof is accepted;
  // the two never target the same slot, so both land in one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
    end else begin
      for (int i = 0; i < N_BUFS; i++) begin
        if (commit && wslot == SW'(i))       full[i] <= 1'b1;
        else if (rd_free && oslot == SW'(i)) full[i] <= 1'b0;
      end
    end
  end

  // The RAM read register doubles as the output stage: it only advances
  // when empty or being consumed, so a stall freezes the word in place.
  assign adv     = !dout_valid || dout_ready;
  assign rd_free = dout_valid && dout_ready && dout_eof;
  // With one slot the reader wraps onto the packet whose eof is leaving now.
  assign rd_en   = adv && full[rslot] && !(rd_free && oslot == rslot);

  // payload RAM, not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= rx_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // read pointer, output flags and packet header for the word in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid <= 1'b0;
      dout_sof   <= 1'b0;
      dout_eof   <= 1'b0;
      pkt_seq    <= '0;
      rcnt       <= '0;
      rslot      <= '0;
      oslot      <= '0;
    end else if (adv) begin
      dout_valid <= rd_en;
      dout_sof   <= rd_en && rcnt == '0;
      dout_eof   <= rd_en && rcnt == LAST;
      if (rd_en) begin
        oslot <= rslot;
        if (rcnt == '0) pkt_seq <= slot_hdr[rslot];
        if (rcnt == LAST) begin
          rcnt  <= '0;
          rslot <= slot_inc(rslot);
        end else begin
          rcnt <= rcnt + WW'(1);
        end
      end
    end
  end

  // masked so the output reads zero whenever no word is presented
  assign dout = dout_valid ? rd_data : '0;

endmodule
